// File: rtl/dmem_lsu.sv
// dmem_lsu: per-core load/store unit in front of one data-memory port.
// Byte-addressed core requests become word-indexed memory accesses; sub-word
// stores use read-modify-write, sub-word loads are lane-extracted and extended.
// Optional build macro: DMEM_LSU_MISALIGN_TRAP_EN (misaligned requests are
// answered with resp_err instead of being aligned down).
module dmem_lsu #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WRITE  = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic                  signed_q, signed_d;
  logic [DEPTH_LOG2+1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [31:0]           merged_q, merged_d;
  logic                  mem_we_s;
  logic [31:0]           mem_addr_s, mem_wdata_s;
  logic [31:0]           word_idx_s;
  logic                  unused_addr_bits;

  // Address bits above the memory size are dropped: accesses wrap.
  assign unused_addr_bits = &{1'b0, req_addr[31:DEPTH_LOG2+2]};
  assign word_idx_s       = 32'(addr_q[DEPTH_LOG2+1:2]);

  // Little-endian lane extraction with sign/zero extension; size 3 acts as word.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] off, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'd0:    res = {{24{sgn & b[7]}}, b};
      2'd1:    res = {{16{sgn & h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Merge right-aligned store data into the selected byte or half lane.
  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] off, input logic [31:0] wd);
    logic [31:0] res;
    res = word;
    if (size == 2'd0) begin
      case (off)
        2'd0:    res[7:0]   = wd[7:0];
        2'd1:    res[15:8]  = wd[7:0];
        2'd2:    res[23:16] = wd[7:0];
        default: res[31:24] = wd[7:0];
      endcase
    end else if (off[1]) begin
      res[31:16] = wd[15:0];
    end else begin
      res[15:0] = wd[15:0];
    end
    return res;
  endfunction

`ifdef DMEM_LSU_MISALIGN_TRAP_EN
  logic err_q, err_d;

  // Half needs addr[0] clear, word (and size 3) needs addr[1:0] clear.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic res;
    case (size)
      2'd0:    res = 1'b0;
      2'd1:    res = off[0];
      default: res = (off != 2'd0);
    endcase
    return res;
  endfunction
`endif

  // Next-state, request latching and memory-port drive.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    signed_d    = signed_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    merged_d    = merged_q;
    mem_we_s    = 1'b0;
    mem_addr_s  = 32'd0;
    mem_wdata_s = 32'd0;
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
    err_d       = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          size_d   = req_size;
          signed_d = req_signed;
          addr_d   = req_addr[DEPTH_LOG2+1:0];
          wdata_d  = req_wdata;
          rdata_d  = 32'd0;
          state_d  = S_ACCESS;
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
          err_d    = is_misaligned(req_size, req_addr[1:0]);
          if (err_d) begin
            state_d = S_RESP;
          end else begin
            state_d = S_ACCESS;
          end
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        mem_addr_s = word_idx_s;
        if (!we_q) begin
          rdata_d = load_extract(mem_rdata, size_q, addr_q[1:0], signed_q);
          state_d = S_RESP;
        end else if (size_q[1]) begin
          mem_we_s    = 1'b1;
          mem_wdata_s = wdata_q;
          rdata_d     = 32'd0;
          state_d     = S_RESP;
        end else begin
          merged_d = store_merge(mem_rdata, size_q, addr_q[1:0], wdata_q);
          rdata_d  = 32'd0;
          state_d  = S_WRITE;
        end
      end
      S_WRITE: begin
        mem_addr_s  = word_idx_s;
        mem_we_s    = 1'b1;
        mem_wdata_s = merged_q;
        state_d     = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      size_q   <= 2'd0;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      merged_q <= 32'd0;
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      merged_q <= merged_d;
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
      err_q    <= err_d;
`endif
    end
  end

  // Reset masks every output so an in-flight write or response is suppressed.
  assign req_ready  = (state_q == S_IDLE) & ~rst;
  assign resp_valid = (state_q == S_RESP) & ~rst;
  assign resp_rdata = resp_valid ? rdata_q : 32'd0;
  assign mem_we     = mem_we_s & ~rst;
  assign mem_addr   = rst ? 32'd0 : mem_addr_s;
  assign mem_wdata  = rst ? 32'd0 : mem_wdata_s;
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
  assign resp_err   = resp_valid & err_q;
`else
  assign resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: randomized and directed bench for dmem_lsu against a
// byte-array reference model of the memory.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:255];
  logic [7:0]  rb  [0:1023];
  int          errors = 0;
  int          checks = 0;

  dmem_lsu #(.DEPTH_LOG2(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int unsigned nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic int unsigned base_of(input logic [31:0] a);
    return ((a / 4) % 256) * 4;
  endfunction

  function automatic int unsigned off_of(input logic [31:0] a, input logic [1:0] sz);
    int unsigned n;
    n = nbytes(sz);
    return ((a % 4) / n) * n;
  endfunction

  function automatic logic misaligned(input logic [31:0] a, input logic [1:0] sz);
    return (a % nbytes(sz)) != 0;
  endfunction

  function automatic logic [31:0] ref_word(input int unsigned idx);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < 4; i++) v = v + (32'(rb[idx*4+i]) << (8*i));
    return v;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic sgn);
    int unsigned b, o, n;
    logic [31:0] v;
    b = base_of(a); o = off_of(a, sz); n = nbytes(sz);
    v = 32'd0;
    for (int i = 0; i < int'(n); i++) v = v + (32'(rb[b+o+i]) << (8*i));
    if (sgn && n < 4 && v[8*n-1]) v = v - (32'd1 << (8*n));
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    int unsigned b, o, n;
    b = base_of(a); o = off_of(a, sz); n = nbytes(sz);
    for (int i = 0; i < int'(n); i++) rb[b+o+i] = 8'(wd >> (8*i));
  endtask

  task automatic txn(input logic we, input logic [1:0] sz, input logic sgn,
                     input logic [31:0] a, input logic [31:0] wd, input string tag);
    logic        exp_err;
    logic [31:0] exp_rd;
    int          exp_lat, exp_writes, lat, writes;
    exp_err = 1'b0;
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
    exp_err = misaligned(a, sz);
`endif
    if (exp_err) begin
      exp_rd = 32'd0; exp_lat = 1; exp_writes = 0;
    end else if (we) begin
      exp_rd = 32'd0; exp_lat = (nbytes(sz) == 4) ? 2 : 3; exp_writes = 1;
    end else begin
      exp_rd = ref_load(a, sz, sgn); exp_lat = 2; exp_writes = 0;
    end
    @(negedge clk);
    check({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sgn;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; writes = 0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge clk);
      if (mem_we) writes++;
      if (k == 1 && !exp_err) check({tag, ".addr"}, mem_addr, 32'(base_of(a) / 4));
      if (resp_valid) begin
        lat = k;
        check({tag, ".rdata"}, resp_rdata, exp_rd);
        check({tag, ".err"}, {31'd0, resp_err}, {31'd0, exp_err});
      end
    end
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    check({tag, ".writes"}, 32'(writes), 32'(exp_writes));
    if (we && !exp_err) ref_store(a, sz, wd);
  endtask

  initial begin
    logic [31:0] w;
    logic [1:0]  rsz;
    int          accepts, resps, idle_resp;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      mem[i] = w;
      for (int j = 0; j < 4; j++) rb[i*4+j] = 8'(w >> (8*j));
    end

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.ready", {31'd0, req_ready}, 32'd0);
    check("rst.valid", {31'd0, resp_valid}, 32'd0);
    check("rst.we", {31'd0, mem_we}, 32'd0);
    check("rst.addr", mem_addr, 32'd0);
    check("rst.wdata", mem_wdata, 32'd0);
    check("rst.rdata", resp_rdata, 32'd0);
    check("rst.err", {31'd0, resp_err}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // directed cases
    txn(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, "st_w");
    txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "ld_w");
    txn(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AB, "st_b");
    check("st_b.word", mem[4], 32'h1122AB44);
    txn(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000BEEF, "st_h");
    check("st_h.word", mem[4], 32'hBEEFAB44);
    txn(1'b1, 2'd2, 1'b0, 32'h30, 32'h80FF7F01, "st_w2");
    txn(1'b0, 2'd0, 1'b1, 32'h33, 32'h0, "ld_bs");
    txn(1'b0, 2'd0, 1'b0, 32'h33, 32'h0, "ld_bu");
    txn(1'b0, 2'd1, 1'b1, 32'h32, 32'h0, "ld_hs");
    txn(1'b1, 2'd2, 1'b0, 32'h400, 32'hCAFEF00D, "st_wrap");
    txn(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, "ld_wrap");
    txn(1'b0, 2'd2, 1'b0, 32'h13, 32'h0, "ld_mis");
    txn(1'b1, 2'd1, 1'b0, 32'h45, 32'h00001234, "st_mis");

    // reset asserted during the write cycle of a byte store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 32'h21; req_wdata = 32'h5A;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rmw.rd_we", {31'd0, mem_we}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rmw.abort_we", {31'd0, mem_we}, 32'd0);
    check("rmw.abort_valid", {31'd0, resp_valid}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rmw.ready", {31'd0, req_ready}, 32'd1);
    idle_resp = 0;
    for (int k = 0; k < 4; k++) begin
      if (resp_valid) idle_resp++;
      @(negedge clk);
    end
    check("rmw.noresp", 32'(idle_resp), 32'd0);
    check("rmw.word", mem[8], ref_word(8));

    // valid held high across busy periods: one accept per completion
    accepts = 0; resps = 0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h10;
    for (int k = 0; k < 9; k++) begin
      if (req_valid && req_ready) accepts++;
      if (resp_valid) begin
        resps++;
        check("hs.rdata", resp_rdata, ref_word(4));
      end
      if (k == 8) req_valid = 1'b0;
      @(negedge clk);
    end
    check("hs.accepts", 32'(accepts), 32'd3);
    check("hs.resps", 32'(resps), 32'd3);

    // randomized traffic
    for (int t = 0; t < 150; t++) begin
      rsz = 2'($urandom_range(0, 3));
      w = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 63));
      txn(1'($urandom), rsz, 1'($urandom), w, $urandom, "rnd");
    end

    // final memory image
    @(negedge clk);
    for (int i = 0; i < 256; i++) check("final.mem", mem[i], ref_word(i));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
